// File: rtl/rca_pipe_adder_if.sv
// Streaming handshake bundle for rca_pipe_adder: operand side (in_*) and result side (out_*).
// The ovf member exists only when RCA_PIPE_OVF_EN is defined.
interface rca_pipe_adder_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             crout;
`ifdef RCA_PIPE_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, op1, op2, cin, sub, out_ready,
    input  in_ready, out_valid, sum, crout
`ifdef RCA_PIPE_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, op1, op2, cin, sub, out_ready,
    output in_ready, out_valid, sum, crout
`ifdef RCA_PIPE_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder/subtractor: STAGES slices of WIDTH/STAGES bits, one slice per stage.
// Optional signed-overflow output enabled by defining RCA_PIPE_OVF_EN.
module rca_pipe_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic              clock,
  input  logic              reset,
  rca_pipe_adder_if.slave   bus
);
  localparam int SW = WIDTH / STAGES;

  function automatic logic [SW:0] add_slice(input logic [SW-1:0] a,
                                            input logic [SW-1:0] b,
                                            input logic          c);
    add_slice = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, c};
  endfunction

  logic             adv_s;
  logic [WIDTH-1:0] opb_s;
  logic             cin0_s;

  // The whole pipe moves in lockstep; a stalled result freezes every stage, bubbles included.
  assign adv_s        = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv_s;
  assign opb_s        = bus.sub ? ~bus.op2 : bus.op2;
  assign cin0_s       = bus.sub | bus.cin;

  for (genvar j = 0; j < STAGES; j++) begin : g_stage
    localparam int LO = (j + 1) * SW;
    localparam int HW = WIDTH - LO;

    logic          vld_r;
    logic          carry_r;
    logic [LO-1:0] sum_r;
    logic          vld_in_s;
    logic [SW-1:0] a_s;
    logic [SW-1:0] b_s;
    logic          c_s;
    logic [SW:0]   add_s;
    logic [LO-1:0] sum_in_s;

    if (j == 0) begin : g_first
      assign vld_in_s = bus.in_valid;
      assign a_s      = bus.op1[SW-1:0];
      assign b_s      = opb_s[SW-1:0];
      assign c_s      = cin0_s;
      assign sum_in_s = add_s[SW-1:0];
    end else begin : g_next
      assign vld_in_s = g_stage[j-1].vld_r;
      assign a_s      = g_stage[j-1].g_hi.a_hi_r[SW-1:0];
      assign b_s      = g_stage[j-1].g_hi.b_hi_r[SW-1:0];
      assign c_s      = g_stage[j-1].carry_r;
      assign sum_in_s = {add_s[SW-1:0], g_stage[j-1].sum_r};
    end

    assign add_s = add_slice(a_s, b_s, c_s);

    // Slice result register; data only loads with a valid token so bubbles leave sum/crout untouched.
    always_ff @(posedge clock) begin
      if (reset) begin
        vld_r   <= 1'b0;
        carry_r <= 1'b0;
        sum_r   <= {LO{1'b0}};
      end else if (adv_s) begin
        vld_r <= vld_in_s;
        if (vld_in_s) begin
          carry_r <= add_s[SW];
          sum_r   <= sum_in_s;
        end
      end
    end

    if (j < STAGES - 1) begin : g_hi
      logic [HW-1:0] a_hi_r;
      logic [HW-1:0] b_hi_r;
      logic [HW-1:0] a_hi_in_s;
      logic [HW-1:0] b_hi_in_s;

      if (j == 0) begin : g_src0
        assign a_hi_in_s = bus.op1[WIDTH-1:SW];
        assign b_hi_in_s = opb_s[WIDTH-1:SW];
      end else begin : g_srcn
        assign a_hi_in_s = g_stage[j-1].g_hi.a_hi_r[WIDTH-j*SW-1:SW];
        assign b_hi_in_s = g_stage[j-1].g_hi.b_hi_r[WIDTH-j*SW-1:SW];
      end

      // Skew register for the operand bits that later stages still have to add.
      always_ff @(posedge clock) begin
        if (reset) begin
          a_hi_r <= {HW{1'b0}};
          b_hi_r <= {HW{1'b0}};
        end else if (adv_s && vld_in_s) begin
          a_hi_r <= a_hi_in_s;
          b_hi_r <= b_hi_in_s;
        end
      end
    end

    if (j == STAGES - 1) begin : g_last
      assign bus.out_valid = vld_r;
      assign bus.sum       = sum_r;
      assign bus.crout     = carry_r;

`ifdef RCA_PIPE_OVF_EN
      logic ovf_r;

      // Carry into the MSB is recovered as a^b^s at that bit, then XORed with the carry out.
      always_ff @(posedge clock) begin
        if (reset) begin
          ovf_r <= 1'b0;
        end else if (adv_s && vld_in_s) begin
          ovf_r <= add_s[SW] ^ a_s[SW-1] ^ b_s[SW-1] ^ add_s[SW-1];
        end
      end

      assign bus.ovf = ovf_r;
`endif
    end
  end
endmodule

// File: tb/tb_rca_pipe_adder.sv
// Self-checking bench for rca_pipe_adder: directed vector table, streaming, backpressure, reset
// mid-flight, plus WIDTH=16/STAGES=1 and WIDTH=32/STAGES=8 instances against a reference sum.
module tb_rca_pipe_adder;
  logic clock;
  logic reset;
  int   checks;
  int   failures;

  rca_pipe_adder_if #(.WIDTH(64)) bus64 ();
  rca_pipe_adder_if #(.WIDTH(16)) bus16 ();
  rca_pipe_adder_if #(.WIDTH(32)) bus32 ();

  rca_pipe_adder #(.WIDTH(64), .STAGES(4)) dut64 (.clock(clock), .reset(reset), .bus(bus64));
  rca_pipe_adder #(.WIDTH(16), .STAGES(1)) dut16 (.clock(clock), .reset(reset), .bus(bus16));
  rca_pipe_adder #(.WIDTH(32), .STAGES(8)) dut32 (.clock(clock), .reset(reset), .bus(bus32));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic        sb;
    logic [63:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference arithmetic at w bits: {co,s} = a + (sb ? ~b : b) + (sb ? 1 : ci).
  task automatic model(input int w, input logic [63:0] a, input logic [63:0] b,
                       input logic ci, input logic sb,
                       output logic [63:0] s, output logic co, output logic ov);
    logic [63:0] mask;
    logic [63:0] bb;
    logic [64:0] full;
    mask = (w == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << w) - 64'd1);
    bb   = (sb ? ~b : b) & mask;
    full = {1'b0, a & mask} + {1'b0, bb} + {64'd0, (sb ? 1'b1 : ci)};
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
  endtask

  task automatic run_stream(input int n, input int mode, input int st_start, input int st_len,
                            output int first_pop, output int last_pop);
    logic [64:0] expq[$];
    logic [64:0] e;
    logic [63:0] a, b, s;
    logic        c, co, ov;
    logic        held;
    logic [63:0] held_sum;
    int          sent, got;
    sent = 0; got = 0; held = 1'b0; held_sum = 64'd0;
    first_pop = -1; last_pop = -1;
    for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
      bus64.out_ready = !(cyc >= st_start && cyc < st_start + st_len);
      a = (mode == 0) ? 64'(sent) : (64'hffff_ffff_0000_0000 | 64'(sent * 7));
      b = (mode == 0) ? 64'(3 * sent) : (64'h0000_0001_ffff_fff0 + 64'(sent));
      c = sent[0];
      if (sent < n) begin
        bus64.op1 = a; bus64.op2 = b; bus64.cin = c; bus64.sub = 1'b0; bus64.in_valid = 1'b1;
      end else begin
        bus64.in_valid = 1'b0;
      end
      #1;
      if (held) begin
        chk("hold_valid", 64'(bus64.out_valid), 64'd1);
        chk("hold_sum", bus64.sum, held_sum);
      end
      if (bus64.out_valid && !bus64.out_ready) chk("stall_in_ready", 64'(bus64.in_ready), 64'd0);
      if (bus64.out_valid && bus64.out_ready) begin
        chk("no_duplicate", 64'(expq.size() > 0), 64'd1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("stream_sum", bus64.sum, e[63:0]);
          chk("stream_crout", 64'(bus64.crout), 64'(e[64]));
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        got++;
      end
      if (bus64.in_valid && bus64.in_ready) begin
        if (mode == 0) begin
          e = {1'b0, 64'(4 * sent) + 64'(c)};
        end else begin
          model(64, a, b, c, 1'b0, s, co, ov);
          e = {co, s};
        end
        expq.push_back(e);
        sent++;
      end
      held     = bus64.out_valid && !bus64.out_ready;
      held_sum = bus64.sum;
      @(posedge clock);
      #1;
    end
    bus64.in_valid = 1'b0;
    chk("stream_count", 64'(got), 64'(n));
  endtask

  initial begin
    int fp, lp, f16, f32, got16, got32;
    logic [63:0] a, b, s;
    logic        c, sb, co, ov;
    logic [65:0] e;
    logic [65:0] q16[$];
    logic [65:0] q32[$];

    checks = 0; failures = 0;
    vecs[0] = '{64'hffff_ffff_ffff_ffff, 64'heeee_dddd_cccc_ffff, 1'b0, 1'b0, 64'heeee_dddd_cccc_fffe, 1'b1, 1'b0};
    vecs[1] = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hffff_ffff_ffff_fffe, 1'b0, 1'b0};
    vecs[2] = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
    vecs[3] = '{64'h7fff_ffff_ffff_ffff, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0};
    vecs[5] = '{64'hffff_ffff_ffff_ffff, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7fff_ffff_ffff_ffff, 1'b1, 1'b1};
    vecs[7] = '{64'h0000_0000_ffff_ffff, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[8] = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0};
    vecs[9] = '{64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 1'b0, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};

    reset = 1'b1;
    bus64.in_valid = 1'b0; bus64.out_ready = 1'b0; bus64.op1 = 64'd0; bus64.op2 = 64'd0;
    bus64.cin = 1'b0; bus64.sub = 1'b0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.op1 = 16'd0; bus16.op2 = 16'd0;
    bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1; bus32.op1 = 32'd0; bus32.op2 = 32'd0;
    bus32.cin = 1'b0; bus32.sub = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset_out_valid", 64'(bus64.out_valid), 64'd0);
    chk("reset_in_ready", 64'(bus64.in_ready), 64'd1);
    chk("reset_sum", bus64.sum, 64'd0);
    chk("reset_crout", 64'(bus64.crout), 64'd0);

    // Directed vectors, one at a time, with exact latency check.
    bus64.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus64.op1 = vecs[i].a; bus64.op2 = vecs[i].b; bus64.cin = vecs[i].ci; bus64.sub = vecs[i].sb;
      bus64.in_valid = 1'b1;
      tick();
      bus64.in_valid = 1'b0;
      tick(); tick();
      chk("vec_latency_early", 64'(bus64.out_valid), 64'd0);
      tick();
      chk("vec_out_valid", 64'(bus64.out_valid), 64'd1);
      chk("vec_sum", bus64.sum, vecs[i].s);
      chk("vec_crout", 64'(bus64.crout), 64'(vecs[i].co));
`ifdef RCA_PIPE_OVF_EN
      chk("vec_ovf", 64'(bus64.ovf), 64'(vecs[i].ov));
`endif
    end
    tick();
    chk("bubble_out_valid", 64'(bus64.out_valid), 64'd0);

    // Back-to-back streaming: 8 results on consecutive cycles from cycle 4.
    run_stream(8, 0, 1000, 0, fp, lp);
    chk("stream_first_cycle", 64'(fp), 64'd4);
    chk("stream_consecutive", 64'(lp - fp), 64'd7);

    // Streaming with 5 cycles of backpressure.
    run_stream(12, 1, 5, 5, fp, lp);
    chk("stall_first_cycle", 64'(fp), 64'd4);
    chk("stall_span", 64'(lp - fp), 64'd16);
    tick(); tick(); tick(); tick();

    // Reset with three transactions in flight, plus a simultaneous offer that must be dropped.
    bus64.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus64.op1 = 64'(i + 1); bus64.op2 = 64'd100; bus64.cin = 1'b0; bus64.sub = 1'b0;
      bus64.in_valid = 1'b1;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus64.in_valid = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(bus64.out_valid), 64'd0);
    chk("midreset_in_ready", 64'(bus64.in_ready), 64'd1);
    chk("midreset_sum", bus64.sum, 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale_result", 64'(bus64.out_valid), 64'd0);
    end

    // Other geometries against the reference arithmetic.
    got16 = 0; got32 = 0; f16 = -1; f32 = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc < 20) begin
        bus16.op1 = 16'($urandom); bus16.op2 = 16'($urandom);
        bus16.cin = 1'($urandom_range(0, 1)); bus16.sub = 1'($urandom_range(0, 1));
        bus16.in_valid = 1'b1;
        bus32.op1 = $urandom; bus32.op2 = (cyc == 0) ? 32'h0000_0001 : $urandom;
        if (cyc == 0) bus32.op1 = 32'h7fff_ffff;
        bus32.cin = 1'($urandom_range(0, 1)); bus32.sub = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        bus32.in_valid = 1'b1;
      end else begin
        bus16.in_valid = 1'b0;
        bus32.in_valid = 1'b0;
      end
      #1;
      if (bus16.out_valid) begin
        chk("w16_no_duplicate", 64'(q16.size() > 0), 64'd1);
        if (q16.size() > 0) begin
          e = q16.pop_front();
          chk("w16_sum", 64'(bus16.sum), e[63:0]);
          chk("w16_crout", 64'(bus16.crout), 64'(e[64]));
`ifdef RCA_PIPE_OVF_EN
          chk("w16_ovf", 64'(bus16.ovf), 64'(e[65]));
`endif
        end
        if (f16 < 0) f16 = cyc;
        got16++;
      end
      if (bus32.out_valid) begin
        chk("w32_no_duplicate", 64'(q32.size() > 0), 64'd1);
        if (q32.size() > 0) begin
          e = q32.pop_front();
          chk("w32_sum", 64'(bus32.sum), e[63:0]);
          chk("w32_crout", 64'(bus32.crout), 64'(e[64]));
`ifdef RCA_PIPE_OVF_EN
          chk("w32_ovf", 64'(bus32.ovf), 64'(e[65]));
`endif
        end
        if (f32 < 0) f32 = cyc;
        got32++;
      end
      if (bus16.in_valid && bus16.in_ready) begin
        a = 64'(bus16.op1); b = 64'(bus16.op2); c = bus16.cin; sb = bus16.sub;
        model(16, a, b, c, sb, s, co, ov);
        q16.push_back({ov, co, s});
      end
      if (bus32.in_valid && bus32.in_ready) begin
        a = 64'(bus32.op1); b = 64'(bus32.op2); c = bus32.cin; sb = bus32.sub;
        model(32, a, b, c, sb, s, co, ov);
        q32.push_back({ov, co, s});
      end
      @(posedge clock);
      #1;
    end
    chk("w16_count", 64'(got16), 64'd20);
    chk("w32_count", 64'(got32), 64'd20);
    chk("w16_first_cycle", 64'(f16), 64'd1);
    chk("w32_first_cycle", 64'(f32), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rca_pipe_adder.md
Name: rca_pipe_adder

Overview:
Parametrised, pipelined ripple-carry adder/subtractor and the successor of the fixed 64-bit RCA. Operand width is split into STAGES equal slices, and each pipeline stage ripples one slice. Carry and the not-yet-added upper operand bits are skewed forward through registers. Valid/ready handshakes on input and output let it sit in streaming datapaths with one result per clock at full throughput.

Parameters:
WIDTH, 64, operand/sum width in bits; must be an integer multiple of STAGES
STAGES, 4, number of pipeline stages (1..WIDTH); slice width SW = WIDTH/STAGES

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  op1/op2/cin/sub valid this cycle
in_ready  output  1  block can accept a transaction this cycle
op1  input  WIDTH  operand A, unsigned/two's complement
op2  input  WIDTH  operand B
cin  input  1  carry-in, used when sub=0
sub  input  1  1 = op1 - op2 (op2 inverted, carry-in forced to 1, cin ignored)
out_valid  output  1  sum/crout hold a valid result
out_ready  input  1  downstream accepts the result this cycle
sum  output  WIDTH  result, modulo 2^WIDTH
crout  output  1  carry out of MSB; for sub=1, 1 = no borrow (op1 >= op2 unsigned)

Behaviour:
- Reset (sync, active-high, sampled on clock edge):
  - All stage valid bits, sum, crout (and ovf if present) go to 0.
  - in_ready reads 1 in the cycle after reset.
  - Any in-flight transactions are discarded.
  - reset overrides a simultaneous acceptance.
- Global advance signal: adv = ~out_valid | out_ready.
  - in_ready = adv, combinational; no combinational path from in_valid.
- Acceptance: in_valid & in_ready at a rising edge.
  - Stage 0 registers slice 0 sum plus carry.
  - Stage 0 also registers the remaining operand bits (op2 pre-inverted if sub) and the valid bit.
- Stage k (1..STAGES-1), when adv=1:
  - Adds slice k of the delayed operands using the carry from stage k-1.
  - Forwards the completed lower-slice sums and the valid bit.
- When adv=0, every stage register holds, including bubbles. Bubbles are not collapsed.
- Latency:
  - A transaction accepted at edge N with no stalls gives out_valid=1 in the cycle after edge N+STAGES-1.
  - STAGES=1 is a single registered adder.
- Throughput: one transaction per cycle while out_ready=1.
- Output hold: while out_valid=1 and out_ready=0, sum/crout/out_valid are stable and no input is accepted.
- Simultaneous pop and push (out_valid & out_ready & in_valid) is allowed; the pipe shifts by one.
- Bubble output: when no valid data reaches the last stage, out_valid=0. sum/crout keep their last value and carry no meaning.
- Arithmetic:
  - {crout,sum} = op1 + (sub ? ~op2 : op2) + (sub ? 1 : cin), computed exactly at WIDTH+1 bits.
  - Wrap-around is modulo 2^WIDTH.
- Ordering: strictly in order; no reordering or dropping except on reset.

Optional Feature:
RCA_PIPE_OVF_EN
- Defined: adds output port ovf (1 bit), registered and aligned with sum/crout.
  - ovf = signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - ovf resets to 0.
- Undefined: no ovf port and no extra logic. All other behaviour is identical.

Test Plan:
- Reset, then op1=64'hffff_ffff_ffff_ffff, op2=64'heeee_dddd_cccc_ffff, cin=0, sub=0 -> after 4 cycles out_valid=1, sum=64'heeee_dddd_cccc_fffe, crout=1.
- Subtract: op1=5, op2=7, sub=1 -> sum=64'hffff_ffff_ffff_fffe, crout=0; then op1=7, op2=5, sub=1 -> sum=2, crout=1.
- Streaming: 8 back-to-back transactions (op1=i, op2=i*3, cin=i[0]), out_ready=1 -> results 4*i+cin appear on 8 consecutive cycles starting cycle 4, in order.
- Backpressure: out_ready=0 for 5 cycles while streaming -> in_ready=0 once out_valid=1, output held stable; no loss or duplication after out_ready returns to 1.
- Reset mid-operation: assert reset with 3 transactions in flight -> next cycle out_valid=0, in_ready=1; no stale result ever appears.
- With RCA_PIPE_OVF_EN: op1=64'h7fff_ffff_ffff_ffff, op2=1 -> sum=64'h8000_0000_0000_0000, ovf=1, crout=0. Repeat with WIDTH=16, STAGES=1 and WIDTH=32, STAGES=8 against a behavioural model.
